// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers per-bit and per-group generate/propagate; stage 2 resolves carries and the sum.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || !(GROUP == 2 || GROUP == 4 || GROUP == 8)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP, GROUP must be 2, 4 or 8");
  end

  // Carry into position n of a lookahead block, built as a flat sum of products.
  function automatic logic cla_carry(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                     input logic c, input int n);
    logic res;
    logic term;
    res = c;
    for (int j = 0; j < WIDTH; j++) begin
      if (j < n) res = res & p[j];
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (j < n) begin
        term = g[j];
        for (int m = 0; m < WIDTH; m++) begin
          if (m > j && m < n) term = term & p[m];
        end
        res = res | term;
      end
    end
    return res;
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_yeff_p0;
  logic [WIDTH-1:0] w_g_p0;
  logic [WIDTH-1:0] w_p_p0;
  logic             w_c0_p0;
  logic [NG-1:0]    w_gg_p0;
  logic [NG-1:0]    w_gp_p0;

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_x_p1;
  logic [WIDTH-1:0] r_yeff_p1;
  logic [WIDTH-1:0] r_g_p1;
  logic [WIDTH-1:0] r_p_p1;
  logic             r_c0_p1;
  logic [NG-1:0]    r_gg_p1;
  logic [NG-1:0]    r_gp_p1;

  logic [NG:0]      w_gcar_p1;
  logic [WIDTH:0]   w_c_p1;
  logic [WIDTH-1:0] w_sum_p1;

  logic             r_vld_p2;
  logic [WIDTH-1:0] r_sum_p2;
  logic             r_cout_p2;
  logic             r_ovf_p2;
  logic             r_zero_p2;

  // Whole pipe moves together; a stalled output freezes both stages.
  assign w_adv    = !r_vld_p2 || out_ready;
  assign in_ready = w_adv;

  // ---- stage 0 -> 1: operand conditioning and group generate/propagate
  assign w_yeff_p0 = sub ? ~y : y;
  assign w_c0_p0   = sub | cin;
  assign w_g_p0    = x & w_yeff_p0;
  assign w_p_p0    = x | w_yeff_p0;

  always_comb begin
    w_gg_p0 = '0;
    w_gp_p0 = '0;
    for (int k = 0; k < NG; k++) begin
      w_gg_p0[k] = cla_carry(w_g_p0 >> (k * GROUP), w_p_p0 >> (k * GROUP), 1'b0, GROUP);
      w_gp_p0[k] = &w_p_p0[k*GROUP +: GROUP];
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_x_p1    <= x;
      r_yeff_p1 <= w_yeff_p0;
      r_g_p1    <= w_g_p0;
      r_p_p1    <= w_p_p0;
      r_c0_p1   <= w_c0_p0;
      r_gg_p1   <= w_gg_p0;
      r_gp_p1   <= w_gp_p0;
    end
  end

  // ---- stage 1 -> 2: group carries, in-group bit carries, sum and flags
  always_comb begin
    w_gcar_p1    = '0;
    w_gcar_p1[0] = r_c0_p1;
    for (int k = 1; k <= NG; k++) begin
      w_gcar_p1[k] = cla_carry(WIDTH'(r_gg_p1), WIDTH'(r_gp_p1), r_c0_p1, k);
    end
  end

  always_comb begin
    w_c_p1 = '0;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        w_c_p1[k*GROUP+i] = cla_carry(r_g_p1 >> (k * GROUP), r_p_p1 >> (k * GROUP),
                                      w_gcar_p1[k], i);
      end
    end
    w_c_p1[WIDTH] = w_gcar_p1[NG];
  end

  assign w_sum_p1 = r_x_p1 ^ r_yeff_p1 ^ w_c_p1[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_sum_p2  <= '0;
      r_cout_p2 <= 1'b0;
      r_ovf_p2  <= 1'b0;
      r_zero_p2 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1  <= in_valid;
      r_vld_p2  <= r_vld_p1;
      r_sum_p2  <= w_sum_p1;
      r_cout_p2 <= w_c_p1[WIDTH];
      r_ovf_p2  <= w_c_p1[WIDTH-1] ^ w_c_p1[WIDTH];
      r_zero_p2 <= ~|w_sum_p1;
    end
  end

  assign out_valid = r_vld_p2;
  assign sum       = r_sum_p2;
  assign carry_out = r_cout_p2;
  assign overflow  = r_ovf_p2;
  assign zero      = r_zero_p2;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed vector table, reset/backpressure sequences and a random sweep over three widths.
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [31:0] rx;
  logic [31:0] ry;

  logic        in_ready_16, out_valid_16, co_16, ov_16, z_16;
  logic [15:0] sum_16;
  logic        in_ready_8, out_valid_8, co_8, ov_8, z_8;
  logic [7:0]  sum_8;
  logic        in_ready_32, out_valid_32, co_32, ov_32, z_32;
  logic [31:0] sum_32;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_16),
    .x(rx[15:0]), .y(ry[15:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid_16), .out_ready(out_ready), .sum(sum_16),
    .carry_out(co_16), .overflow(ov_16), .zero(z_16));

  pipelined_cla_adder #(.WIDTH(8), .GROUP(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_8),
    .x(rx[7:0]), .y(ry[7:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid_8), .out_ready(out_ready), .sum(sum_8),
    .carry_out(co_8), .overflow(ov_8), .zero(z_8));

  pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_32),
    .x(rx), .y(ry), .cin(cin), .sub(sub),
    .out_valid(out_valid_32), .out_ready(out_ready), .sum(sum_32),
    .carry_out(co_32), .overflow(ov_32), .zero(z_32));

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        sub;
  } txn_t;

  vec_t vecs[12];
  txn_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: returns {sum[31:0], carry_out, overflow, zero} for a given width.
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    logic [63:0] m, m1, ye, full, low, s;
    logic        c0, cout, cmsb;
    m    = (64'd1 << w) - 64'd1;
    m1   = (64'd1 << (w - 1)) - 64'd1;
    ye   = sb ? ~{32'h0, b} : {32'h0, b};
    c0   = sb ? 1'b1 : ci;
    full = ({32'h0, a} & m) + (ye & m) + {63'h0, c0};
    low  = ({32'h0, a} & m1) + (ye & m1) + {63'h0, c0};
    s    = full & m;
    cout = full[w];
    cmsb = low[w-1];
    return {s[31:0], cout, cmsb ^ cout, (s == 64'h0)};
  endfunction

  initial begin
    int   sent, got, stall, cyc, done;
    txn_t t;
    logic [34:0] e;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rx = '0; ry = '0; cin = 1'b0; sub = 1'b0;

    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_state", {in_ready_16, out_valid_16, sum_16, co_16, ov_16, z_16},
          {1'b1, 1'b0, 16'h0000, 3'b000});
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rx = {16'h0, vecs[i].x}; ry = {16'h0, vecs[i].y};
      cin = vecs[i].cin; sub = vecs[i].sub; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (i == 0) check("latency_not_early", {63'h0, out_valid_16}, 64'h0);
      @(negedge clk);
      check($sformatf("vec%0d", i), {out_valid_16, sum_16, co_16, ov_16, z_16},
            {1'b1, vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z});
    end

    @(negedge clk);
    rx = 32'h1111; ry = 32'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    rx = 32'h0101; ry = 32'h0202;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_reset", {out_valid_16, sum_16}, {1'b1, 16'h3333});
    rst_n = 1'b0;
    #1;
    check("reset_mid", {in_ready_16, out_valid_16, sum_16, co_16, ov_16, z_16},
          {1'b1, 1'b0, 16'h0000, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_stale", {63'h0, out_valid_16}, 64'h0);
    end

    sent = 0; got = 0; stall = 0; cyc = 0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      out_ready = !(out_valid_16 && stall < 3);
      in_valid  = (sent < 4);
      rx = 32'(sent + 1); ry = 32'h1; cin = 1'b0; sub = 1'b0;
      #1;
      if (!out_ready) begin
        stall++;
        check("bp_stall", {in_ready_16, out_valid_16, sum_16}, {1'b0, 1'b1, 16'd2});
      end
      if (out_valid_16 && out_ready) begin
        check("bp_order", {48'h0, sum_16}, 64'(got + 2));
        got++;
      end
      if (in_valid && in_ready_16) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", 64'(got), 64'd4);
    check("bp_stall_cycles", 64'(stall), 64'd3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_no_dup", {63'h0, out_valid_16}, 64'h0);
    end

    done = 0; cyc = 0;
    while (done < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      rx = $urandom; ry = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid_16 && out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious", 64'h1, 64'h0);
        end else begin
          t = q.pop_front();
          e = model(16, t.x, t.y, t.cin, t.sub);
          check("rand_w16", {out_valid_16, in_ready_16, 16'h0, sum_16, co_16, ov_16, z_16},
                {1'b1, 1'b1, e});
          e = model(8, t.x, t.y, t.cin, t.sub);
          check("rand_w8", {out_valid_8, in_ready_8, 24'h0, sum_8, co_8, ov_8, z_8},
                {1'b1, 1'b1, e});
          e = model(32, t.x, t.y, t.cin, t.sub);
          check("rand_w32", {out_valid_32, in_ready_32, sum_32, co_32, ov_32, z_32},
                {1'b1, 1'b1, e});
          done++;
        end
      end
      if (in_valid && in_ready_16) q.push_back('{rx, ry, cin, sub});
    end
    if (done < 10000) check("rand_timeout", 64'(done), 64'd10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
